spi_fifo_master: RTL

SPI master byte engine that sits between the TX/RX spi_fifo instances and the SD card pins. It drains bytes from the TX FIFO read port and serialises them MSB-first in SPI mode 0 (CPOL=0, CPHA=0). Each received MISO byte is pushed into the RX FIFO write port. Chip-select stays asserted across back-to-back bytes while TX data is available.

---
 rtl/spi_fifo_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_fifo_master.sv
// SPI mode-0 master byte engine: pops bytes from a TX FIFO, shifts them out MSB-first
// and pushes each received byte into an RX FIFO, holding chip-select across back-to-back bytes.
module spi_fifo_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             enable,
    output logic             tx_fifo_rd_en,
    input  logic [WIDTH-1:0] tx_fifo_rd_data,
    input  logic             tx_fifo_rd_empty,
    output logic             rx_fifo_wr_en,
    output logic [WIDTH-1:0] rx_fifo_wr_data,
    input  logic             rx_fifo_wr_full,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_cs_n,
    output logic             busy,
    output logic             rx_overflow,
    input  logic             clear_overflow
);

    localparam int BCW = $clog2(WIDTH) + 1;
    localparam logic [7:0]     DIV_TC   = 8'(CLK_DIV - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        STORE = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       div_r, div_s;
    logic [BCW-1:0]   bit_r, bit_s;
    logic [WIDTH-1:0] tx_sr_r, tx_sr_s;
    logic [WIDTH-1:0] rx_sr_r, rx_sr_s;
    logic             rd_en_s, wr_en_s, sck_s, mosi_s, cs_n_s, busy_s, ovf_s, ovf_set_s;
    logic [WIDTH-1:0] wr_data_s;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s   = state_r;
        div_s     = div_r;
        bit_s     = bit_r;
        tx_sr_s   = tx_sr_r;
        rx_sr_s   = rx_sr_r;
        rd_en_s   = 1'b0;
        wr_en_s   = 1'b0;
        wr_data_s = rx_fifo_wr_data;
        sck_s     = spi_sck;
        mosi_s    = spi_mosi;
        cs_n_s    = spi_cs_n;
        ovf_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                cs_n_s = 1'b1;
                sck_s  = 1'b0;
                if (enable && !tx_fifo_rd_empty) begin
                    rd_en_s = 1'b1;
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                state_s = LOAD;
            end
            LOAD: begin
                tx_sr_s = tx_fifo_rd_data;
                mosi_s  = tx_fifo_rd_data[WIDTH-1];
                cs_n_s  = 1'b0;
                div_s   = 8'd0;
                bit_s   = {BCW{1'b0}};
                state_s = SHIFT;
            end
            SHIFT: begin
                if (div_r == DIV_TC) begin
                    div_s = 8'd0;
                    if (!spi_sck) begin
                        // Rising SCK: sample MISO on the same clk edge that raises SCK.
                        sck_s   = 1'b1;
                        rx_sr_s = {rx_sr_r[WIDTH-2:0], spi_miso};
                    end else begin
                        sck_s = 1'b0;
                        bit_s = bit_r + BCW'(1);
                        if (bit_r == LAST_BIT) begin
                            state_s = STORE;
                        end else begin
                            tx_sr_s = tx_sr_r << 1;
                            mosi_s  = tx_sr_r[WIDTH-2];
                        end
                    end
                end else begin
                    div_s = div_r + 8'd1;
                end
            end
            STORE: begin
                if (!rx_fifo_wr_full) begin
                    wr_en_s   = 1'b1;
                    wr_data_s = rx_sr_r;
                end else begin
                    ovf_set_s = 1'b1;
                end
                // Chain straight into the next byte with CS still low when more data waits.
                if (enable && !tx_fifo_rd_empty) begin
                    rd_en_s = 1'b1;
                    state_s = FETCH;
                end else begin
                    cs_n_s  = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cs_n_s  = 1'b1;
                sck_s   = 1'b0;
            end
        endcase
        if (ovf_set_s) begin
            ovf_s = 1'b1;
        end else if (clear_overflow) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = rx_overflow;
        end
        busy_s = (state_s != IDLE);
    end

    // State, datapath and registered outputs with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r         <= IDLE;
            div_r           <= 8'd0;
            bit_r           <= {BCW{1'b0}};
            tx_sr_r         <= {WIDTH{1'b0}};
            rx_sr_r         <= {WIDTH{1'b0}};
            tx_fifo_rd_en   <= 1'b0;
            rx_fifo_wr_en   <= 1'b0;
            rx_fifo_wr_data <= {WIDTH{1'b0}};
            spi_sck         <= 1'b0;
            spi_mosi        <= 1'b0;
            spi_cs_n        <= 1'b1;
            busy            <= 1'b0;
            rx_overflow     <= 1'b0;
        end else begin
            state_r         <= state_s;
            div_r           <= div_s;
            bit_r           <= bit_s;
            tx_sr_r         <= tx_sr_s;
            rx_sr_r         <= rx_sr_s;
            tx_fifo_rd_en   <= rd_en_s;
            rx_fifo_wr_en   <= wr_en_s;
            rx_fifo_wr_data <= wr_data_s;
            spi_sck         <= sck_s;
            spi_mosi        <= mosi_s;
            spi_cs_n        <= cs_n_s;
            busy            <= busy_s;
            rx_overflow     <= ovf_s;
        end
    end

endmodule
